// File: rtl/rbfu_resp_collector_if.sv
// Result channel for rbfu_resp_collector: show-ahead head entry with valid/ready.
// master drives valid/tag/d0..d3, slave drives ready.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

interface rbfu_resp_collector_if #(
  parameter int DW    = `DATA_WIDTH,
  parameter int TAG_W = 4
);
  logic             res_valid;
  logic             res_ready;
  logic [TAG_W-1:0] res_tag;
  logic [DW-1:0]    res_d0;
  logic [DW-1:0]    res_d1;
  logic [DW-1:0]    res_d2;
  logic [DW-1:0]    res_d3;

  modport master (
    output res_valid, res_tag,
    output res_d0, res_d1, res_d2, res_d3,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_tag,
    input  res_d0, res_d1, res_d2, res_d3,
    output res_ready
  );
endinterface

// File: rtl/rbfu_resp_collector.sv
// Tracks ops issued into the fixed-latency RBFU, captures Dout0..3 RBFU_LAT cycles
// later into a tagged result FIFO, and gates issue by credits so nothing is dropped.
// Ports: clk, rst (sync, active-high), issue_fire/issue_tag/issue_ok, Dout0..3,
// res (result channel, master modport), err_ovf (sticky issue-without-credit).
// Optional RBFU_COLLECT_STATS_EN adds stat_issued / stat_drained counters.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module rbfu_resp_collector #(
  parameter int DW         = `DATA_WIDTH,
  parameter int TAG_W      = 4,
  parameter int RBFU_LAT   = 80,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             issue_fire,
  input  logic [TAG_W-1:0] issue_tag,
  output logic             issue_ok,
  input  logic [DW-1:0]    Dout0,
  input  logic [DW-1:0]    Dout1,
  input  logic [DW-1:0]    Dout2,
  input  logic [DW-1:0]    Dout3,
  rbfu_resp_collector_if.master res,
  output logic             err_ovf
`ifdef RBFU_COLLECT_STATS_EN
  ,
  output logic [31:0]      stat_issued,
  output logic [31:0]      stat_drained
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = TAG_W + 4 * DW;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic                acc;
  logic                pop;
  logic                push;
  logic                empty;
  logic [RBFU_LAT-1:0] vld_q;
  logic [TAG_W-1:0]    tag_q [RBFU_LAT];
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [CW-1:0]       wr_q, wr_d;
  logic [CW-1:0]       rd_q, rd_d;
  logic                err_q, err_d;
  logic [EW-1:0]       mem_q [FIFO_DEPTH];
  logic [EW-1:0]       head;

  // Credit covers in-flight ops plus FIFO occupancy, so a push always has room.
  assign issue_ok = cnt_q < DEPTH_C;
  assign acc      = issue_fire & issue_ok;
  assign push     = vld_q[RBFU_LAT-1];
  assign empty    = (wr_q == rd_q);
  assign pop      = !empty & res.res_ready;
  assign err_ovf  = err_q;

  // Head forced to zero when empty so idle outputs read as 0.
  assign head = empty ? '0 : mem_q[rd_q[PW-1:0]];

  assign res.res_valid = !empty;
  assign {res.res_tag, res.res_d3, res.res_d2,
          res.res_d1, res.res_d0} = head;

  always_comb begin
    cnt_d = cnt_q + CW'(acc) - CW'(pop);
    wr_d  = wr_q + CW'(push);
    rd_d  = rd_q + CW'(pop);
    err_d = err_q | (issue_fire & !issue_ok);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cnt_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = RBFU_LAT - 1; i > 0; i--)
        vld_q[i] <= vld_q[i-1];
      vld_q[0] <= acc;
      cnt_q    <= cnt_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      err_q    <= err_d;
    end
  end

  // Tag lane needs no reset: only read when its valid bit is set.
  always_ff @(posedge clk) begin
    for (int i = RBFU_LAT - 1; i > 0; i--)
      tag_q[i] <= tag_q[i-1];
    tag_q[0] <= issue_tag;
  end

  always_ff @(posedge clk) begin
    if (!rst && push)
      mem_q[wr_q[PW-1:0]] <= {tag_q[RBFU_LAT-1],
                              Dout3, Dout2, Dout1, Dout0};
  end

`ifdef RBFU_COLLECT_STATS_EN
  logic [31:0] iss_q, iss_d;
  logic [31:0] drn_q, drn_d;

  always_comb begin
    iss_d = iss_q + 32'(acc);
    drn_d = drn_q + 32'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      iss_q <= '0;
      drn_q <= '0;
    end else begin
      iss_q <= iss_d;
      drn_q <= drn_d;
    end
  end

  assign stat_issued  = iss_q;
  assign stat_drained = drn_q;
`endif

endmodule

// File: tb/tb_rbfu_resp_collector.sv
// Testbench for rbfu_resp_collector: directed + random stimulus
// against a queue-based reference model.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_rbfu_resp_collector;
  localparam int DW  = `DATA_WIDTH;
  localparam int LAT = 80;
  localparam int DEP = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          fire;
  logic [3:0]    tg;
  logic          ok;
  logic          err;
  logic [DW-1:0] d0, d1, d2, d3;
`ifdef RBFU_COLLECT_STATS_EN
  logic [31:0]   s_iss, s_drn;
`endif

  rbfu_resp_collector_if #(.DW(DW), .TAG_W(4)) rif ();

  rbfu_resp_collector #(
    .DW(DW), .TAG_W(4), .RBFU_LAT(LAT), .FIFO_DEPTH(DEP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .issue_fire(fire),
    .issue_tag(tg),
    .issue_ok(ok),
    .Dout0(d0),
    .Dout1(d1),
    .Dout2(d2),
    .Dout3(d3),
    .res(rif),
    .err_ovf(err)
`ifdef RBFU_COLLECT_STATS_EN
    ,
    .stat_issued(s_iss),
    .stat_drained(s_drn)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [3:0] tag;
  } fl_t;

  typedef struct {
    logic [3:0]    tag;
    logic [DW-1:0] a, b, c, d;
  } ent_t;

  fl_t         infl[$];
  ent_t        fq[$];
  logic        m_err;
  logic [31:0] m_iss, m_drn;
  int          cyc;
  int          errs;
  int          total;

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd();
    logic [63:0] v;
    v = {$urandom, $urandom};
    return v[DW-1:0];
  endfunction

  // One cycle: drive, check outputs against model, then advance model and clock.
  task automatic step(input logic r, input logic f,
                      input logic [3:0] t, input logic rdy);
    logic e_ok;
    logic e_pop;
    ent_t e;
    rst = r;
    fire = f;
    tg = t;
    rif.res_ready = rdy;
    d0 = rnd();
    d1 = rnd();
    d2 = rnd();
    d3 = rnd();
    #1;
    e_ok = (infl.size() + fq.size()) < DEP;
    chk("issue_ok", ok, e_ok);
    chk("res_valid", rif.res_valid, fq.size() > 0);
    chk("err_ovf", err, m_err);
    if (fq.size() > 0) begin
      chk("res_tag", rif.res_tag, fq[0].tag);
      chk("res_d0", rif.res_d0, fq[0].a);
      chk("res_d1", rif.res_d1, fq[0].b);
      chk("res_d2", rif.res_d2, fq[0].c);
      chk("res_d3", rif.res_d3, fq[0].d);
    end
`ifdef RBFU_COLLECT_STATS_EN
    chk("stat_issued", s_iss, m_iss);
    chk("stat_drained", s_drn, m_drn);
`endif
    if (r) begin
      infl.delete();
      fq.delete();
      m_err = 1'b0;
      m_iss = '0;
      m_drn = '0;
    end else begin
      e_pop = (fq.size() > 0) && rdy;
      if (e_pop) begin
        void'(fq.pop_front());
        m_drn++;
      end
      if (f) begin
        if (e_ok) begin
          infl.push_back('{cyc + LAT, t});
          m_iss++;
        end else begin
          m_err = 1'b1;
        end
      end
      if (infl.size() > 0 && infl[0].due == cyc) begin
        e.tag = infl[0].tag;
        e.a = d0;
        e.b = d1;
        e.c = d2;
        e.d = d3;
        fq.push_back(e);
        void'(infl.pop_front());
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    errs = 0;
    total = 0;
    cyc = 0;
    m_err = 1'b0;
    m_iss = '0;
    m_drn = '0;
    rst = 1'b1;
    fire = 1'b0;
    tg = '0;
    rif.res_ready = 1'b0;
    d0 = '0;
    d1 = '0;
    d2 = '0;
    d3 = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;

    chk("rst_issue_ok", ok, 1'b1);
    chk("rst_res_valid", rif.res_valid, 1'b0);
    chk("rst_res_tag", rif.res_tag, 4'd0);
    chk("rst_res_d0", rif.res_d0, '0);
    chk("rst_res_d3", rif.res_d3, '0);
    chk("rst_err_ovf", err, 1'b0);

    // single issue, tag 5
    step(0, 1, 4'd5, 1);
    repeat (LAT + 10) step(0, 0, 4'd0, 1);

    // stream of 8 back-to-back
    for (int i = 0; i < 8; i++) step(0, 1, 4'(i), 1);
    repeat (LAT + 12) step(0, 0, 4'd0, 1);

    // backpressure: 20 fires, only 16 accepted, err_ovf set
    for (int i = 0; i < 20; i++) step(0, 1, 4'($urandom), 0);
    repeat (LAT + 5) step(0, 0, 4'd0, 0);

    // credit return: one pop pulse frees one credit next cycle
    step(0, 0, 4'd0, 1);
    step(0, 0, 4'd0, 0);
    step(0, 1, 4'd9, 0);
    step(0, 0, 4'd0, 0);
    repeat (LAT + 25) step(0, 0, 4'd0, 1);

    // random traffic
    for (int i = 0; i < 600; i++)
      step(0, 1'($urandom_range(0, 1)), 4'($urandom),
           1'($urandom_range(0, 3) != 0));
    repeat (LAT + 20) step(0, 0, 4'd0, 1);

    // reset mid-flight
    step(1, 0, 4'd0, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 4'(i + 1), 1);
    repeat (36) step(0, 0, 4'd0, 1);
    step(1, 0, 4'd0, 1);
    repeat (200) step(0, 0, 4'd0, 1'($urandom_range(0, 1)));

    // random with heavy backpressure
    for (int i = 0; i < 300; i++)
      step(0, 1'($urandom_range(0, 1)), 4'($urandom),
           1'($urandom_range(0, 3) == 0));
    repeat (LAT + 40) step(0, 0, 4'd0, 1);

    $display("Result: errors=%0d of %0d checks", errs, total);
    $finish;
  end

endmodule
